li_upsampler: RTL and testbench
===============================

# li_upsampler

Linear-interpolation upsampler that sits directly downstream of the L+R / L−R scaling stage. It accepts one signed sample per audio period on a valid strobe and emits R = 2^LOG2_R linearly interpolated samples per period, one per output-rate tick, toward the modulator's high-rate path. One instance is used per channel: one for LpR and one for LmR.

## Interface
- `W`, 18: sample width, signed two's complement.
- `LOG2_R`, 3: log2 of the upsampling factor R. The legal range is 1..6.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `din`  in  W  input sample, signed. Sampled only when `din_valid`=1.
- `din_valid`  in  1  one-cycle strobe marking a new input sample. Driven by the upstream `ready_out_*`.
- `out_tick`  in  1  one-cycle clock enable at the output rate, nominally R per `din_valid` period.
- `dout`  out  W  interpolated sample, signed, registered.
- `dout_valid`  out  1  one-cycle pulse; `dout` is new this cycle.
- `overrun`  out  1  sticky flag: a new sample arrived early.
- `underrun`  out  1  sticky flag: an output tick arrived after the segment was exhausted.

## Operation
- **Registers**
  - `x_cur` (W): current sample.
  - `delta` (W+1): slope.
  - `acc` (W+LOG2_R+1): scaled interpolation value.
  - `k` (LOG2_R+1): ticks emitted in the current segment.
  - `state`.
- **States**
  - EMPTY: after reset, no sample received yet.
  - RUN: interpolating the current segment.
  - HOLD: all R points of the segment have been emitted.
- **Load**, on `din_valid` in any state:
  - `delta` ← `din` − `x_cur`, computed at W+1 bits and exact.
  - `acc` ← `x_cur` << LOG2_R.
  - `x_cur` ← `din`.
  - `k` ← 0.
  - `state` ← RUN.
  - The first segment after reset starts from `x_cur` = 0.
- **Tick**, on `out_tick` in RUN:
  - `dout` ← Q(`acc`).
  - `acc` ← `acc` + `delta`.
  - `k` ← `k` + 1.
  - When `k` reaches R, `state` ← HOLD.
- **Tick in HOLD:** `dout` ← `x_cur`, `dout_valid` pulses, `underrun` is set, `acc` and `k` are unchanged.
- **Tick in EMPTY:** ignored. No `dout_valid`, no flag.
- **Quantiser Q:** arithmetic shift right by LOG2_R, with rounding controlled by the `LI_ROUND_EN` macro (see Configuration).
  - `acc` always lies between x_prev·R and x_cur·R, so Q(`acc`) fits in W bits. No saturation logic is needed.
- **Simultaneous `din_valid` and `out_tick`:**
  - The load takes priority.
  - The same tick is then processed against the freshly loaded segment: it outputs Q(old `x_cur` << LOG2_R), which equals old `x_cur`, and leaves `k`=1 and `acc` = old `x_cur`·R + `delta`.
- **`overrun`:** set on `din_valid` when `state`=RUN and `k` < R−1. One missing tick is tolerated for phase alignment.
- **Flag reset:** `overrun` and `underrun` are cleared only by reset.

## Timing
- **Reset values** (asynchronous, while `reset`=0):
  - `dout`=0, `dout_valid`=0, `overrun`=0, `underrun`=0.
  - `x_cur`=0, `acc`=0, `k`=0, `state`=EMPTY.
- **Reset release:** synchronous to `clock`. The first `din_valid` is honoured on the first rising edge with `reset`=1.
- **Tick latency:** a tick at edge n produces `dout` and `dout_valid`=1 after edge n. `dout_valid` is low in the following cycle unless another tick occurs.
- **Load latency:** the new slope is in effect for a tick in the same cycle as the load. This gives zero load-to-output latency beyond the one register stage.
- **Tick spacing:** back-to-back ticks on consecutive cycles are legal. The accumulator updates every cycle.
- **Mid-operation reset:** an assertion at any point aborts the segment immediately. No `dout_valid` is produced until after the next `din_valid`.

## Configuration
- **`LI_ROUND_EN` defined:** Q(`acc`) = (`acc` + 2^(LOG2_R−1)) >>> LOG2_R, i.e. round half toward +∞.
- **`LI_ROUND_EN` undefined:** Q(`acc`) = `acc` >>> LOG2_R, i.e. truncation toward −∞.
- Endpoint outputs (`k`=0 and HOLD) are identical in both builds.

## Test plan
- **Ramp up**, R=8, macro defined: reset, `din`=800 strobe, then 8 ticks → `dout` 0,100,200,…,700. A 9th tick → 800 with `underrun`=1.
- **Negative slope with rounding**, R=8: segment 0 → −3, 8 ticks. With macro defined: 0,0,−1,−1,−1,−2,−2,−3, where ties round toward +∞. With macro undefined: 0,−1,−1,−2,−2,−2,−3,−3.
- **Full scale:** segment −131072 → 131071, 8 ticks → all outputs within [−131072, 131071], monotonic non-decreasing. HOLD outputs 131071.
- **Simultaneous events:** `x_cur`=400, then `din`=0 with `din_valid` and `out_tick` in the same cycle → `dout`=400. The next tick → 350.
- **Early sample:** `din_valid` after only 3 ticks of a segment → `overrun`=1, which remains set. The new segment starts from the old `x_cur`. A later clean segment does not clear the flag.
- **Reset behaviour:** ticks with no sample produce no `dout_valid`. Asserting `reset`=0 mid-segment → all outputs 0 asynchronously. Ticks after release are ignored until `din_valid`.

Source files
------------

// File: rtl/li_upsampler.sv
// li_upsampler: linear-interpolation upsampler, one signed sample per period in, R = 2**LOG2_R interpolated samples out.
//   Optional build macro LI_ROUND_EN: when defined, interpolated points round half toward +inf, otherwise they truncate toward -inf.
//   Ports: clock, reset (async active-low), din/din_valid (input sample strobe), out_tick (output-rate enable),
//          dout/dout_valid (registered interpolated sample), overrun/underrun (sticky pacing flags).
module li_upsampler #(
  parameter int W = 18,
  parameter int LOG2_R = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic signed [W-1:0] din,
  input  logic                din_valid,
  input  logic                out_tick,
  output logic signed [W-1:0] dout,
  output logic                dout_valid,
  output logic                overrun,
  output logic                underrun
);
  localparam int AW = W + LOG2_R + 1;
  localparam logic [LOG2_R:0] R = (LOG2_R + 1)'(1 << LOG2_R);
  typedef enum logic [1:0] {EMPTY, RUN, HOLD} state_t;
  state_t state, state_n, st_b;
  logic signed [W-1:0] x_cur, x_cur_n, dout_n;
  logic signed [W:0] delta, delta_n;
  logic signed [AW-1:0] acc, acc_n, acc_b, x_sc;
  logic [LOG2_R:0] k, k_n, k_b;
  logic run_t, hold_t, dout_valid_n, overrun_n, underrun_n;
  assign x_sc = {{(LOG2_R + 1){x_cur[W-1]}}, x_cur} << LOG2_R;
  // A load is applied first, so a coincident tick sees the freshly loaded segment.
  always_comb begin
    st_b = din_valid ? RUN : state;
    acc_b = din_valid ? x_sc : acc;
    k_b = din_valid ? '0 : k;
    delta_n = din_valid ? {din[W-1], din} - {x_cur[W-1], x_cur} : delta;
    x_cur_n = din_valid ? din : x_cur;
    run_t = out_tick && st_b == RUN;
    hold_t = out_tick && st_b == HOLD;
    acc_n = run_t ? acc_b + AW'(delta_n) : acc_b;
    k_n = run_t ? k_b + 1'b1 : k_b;
    state_n = (run_t && k_b + 1'b1 == R) ? HOLD : st_b;
`ifdef LI_ROUND_EN
    dout_n = run_t ? W'((acc_b + AW'(2 ** (LOG2_R - 1))) >>> LOG2_R) : hold_t ? x_cur : dout;
`else
    dout_n = run_t ? W'(acc_b >>> LOG2_R) : hold_t ? x_cur : dout;
`endif
    dout_valid_n = run_t || hold_t;
    // One missing tick is tolerated so the output phase can slip against the input strobe.
    overrun_n = overrun || (din_valid && state == RUN && k < R - 1'b1);
    underrun_n = underrun || hold_t;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      x_cur <= '0;
      delta <= '0;
      acc <= '0;
      k <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      overrun <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      x_cur <= x_cur_n;
      delta <= delta_n;
      acc <= acc_n;
      k <= k_n;
      dout <= dout_n;
      dout_valid <= dout_valid_n;
      overrun <= overrun_n;
      underrun <= underrun_n;
    end
  end
endmodule

// File: tb/tb_li_upsampler.sv
// tb_li_upsampler: scoreboard bench for li_upsampler (W=18, R=8).
module tb_li_upsampler;
  localparam int W = 18, L = 3, R = 8;
  logic clock = 1'b0, reset = 1'b0;
  logic signed [W-1:0] din = '0;
  logic din_valid = 1'b0, out_tick = 1'b0;
  logic signed [W-1:0] dout;
  logic dout_valid, overrun, underrun;
  int n_checks = 0, n_errors = 0, n_valid = 0;
  longint exp_q[$];
  li_upsampler #(.W(W), .LOG2_R(L)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .out_tick(out_tick),
    .dout(dout), .dout_valid(dout_valid), .overrun(overrun), .underrun(underrun)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint q_ref(input longint v);
`ifdef LI_ROUND_EN
    return (v + R / 2) >>> L;
`else
    return v >>> L;
`endif
  endfunction
  function automatic longint seg(input longint a, input longint b, input int i);
    return q_ref(a * R + i * (b - a));
  endfunction
  always @(negedge clock) begin
    if (dout_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) check("spurious_valid", exp_q.size(), 1);
      else check("dout", dout, exp_q.pop_front());
    end
  end
  task automatic step(input bit dv, input longint d, input bit t, input bit ev, input longint e);
    din_valid = dv;
    din = W'(d);
    out_tick = t;
    if (ev) exp_q.push_back(e);
    @(posedge clock);
    #1;
    din_valid = 1'b0;
    out_tick = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    longint neg_tab[8];
    int nv;
`ifdef LI_ROUND_EN
    neg_tab = '{0, 0, -1, -1, -1, -2, -2, -3};
`else
    neg_tab = '{0, -1, -1, -2, -2, -2, -3, -3};
`endif
    #12;
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_underrun", underrun, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("empty_no_valid", n_valid, 0);
    check("empty_no_underrun", underrun, 0);
    step(1, 800, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, i * 100);
    step(0, 0, 0, 0, 0);
    check("ramp_no_underrun", underrun, 0);
    step(0, 0, 1, 1, 800);
    step(0, 0, 0, 0, 0);
    check("ramp_underrun", underrun, 1);
    check("ramp_overrun", overrun, 0);
    do_reset();
    step(1, -3, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, neg_tab[i]);
    step(0, 0, 0, 0, 0);
    check("neg_underrun", underrun, 0);
    do_reset();
    step(1, -131072, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, seg(0, -131072, i));
    step(1, 131071, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, seg(-131072, 131071, i));
    step(0, 0, 1, 1, 131071);
    step(0, 0, 0, 0, 0);
    check("full_overrun", overrun, 0);
    do_reset();
    step(1, 400, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, i * 50);
    step(1, 0, 1, 1, 400);
    step(0, 0, 1, 1, 350);
    step(0, 0, 0, 0, 0);
    check("simul_overrun", overrun, 0);
    do_reset();
    step(1, 80, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, i * 10);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("overrun_tolerant", overrun, 0);
    do_reset();
    step(1, 800, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, i * 100);
    step(1, 1600, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 800 + i * 100);
    step(0, 0, 0, 0, 0);
    check("early_before", overrun, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("early_overrun", overrun, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1600 - i * 200);
    step(1, 800, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, i * 100);
    step(0, 0, 0, 0, 0);
    check("overrun_sticky", overrun, 1);
    do_reset();
    step(1, 800, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1, i * 100);
    step(1, 1600, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 800 + i * 100);
    step(1, 2400, 0, 0, 0);
    step(0, 0, 1, 1, 1600);
    step(0, 0, 1, 1, 1700);
    step(0, 0, 0, 0, 0);
    check("pre_rst_dout", dout, 1700);
    check("pre_rst_flags", {30'd0, overrun, underrun}, 3);
    #2;
    reset = 1'b0;
    #1;
    check("async_dout", dout, 0);
    check("async_dout_valid", dout_valid, 0);
    check("async_overrun", overrun, 0);
    check("async_underrun", underrun, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    nv = n_valid;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("post_rst_no_valid", n_valid, nv);
    check("post_rst_no_underrun", underrun, 0);
    step(1, 800, 1, 1, 0);
    step(0, 0, 1, 1, 100);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
